mux8_scanner: RTL and testbench

Sequencing front-end for the 8:1 structural multiplexer. It drives the mux select lines S2..S0 through channels 0..7 and waits a programmable settle time on each. It samples the mux output Y per channel and packs the eight samples into one byte frame. The frame is handed downstream over a valid/ready handshake.

---
 rtl/mux8_scan_pkg.sv | 21 ++
 rtl/mux8_settle_timer.sv | 29 ++
 rtl/mux8_scanner.sv | 146 ++++++++++++++
 tb/tb_mux8_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mux8_scan_pkg.sv
// Shared definitions for the 8:1 mux scanner: channel count, select and
// settle-counter widths, and the scanner FSM state encoding.
package mux8_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  // Select value of the final channel of a frame
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // Scanner states; ST_SETTLE waits out the mux, ST_SAMPLE captures Y,
  // ST_FULL holds a completed frame while the output slot is occupied
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

endpackage

// File: rtl/mux8_settle_timer.sv
// Loadable down-counter timing the settle wait after each select change.
// done is high for exactly the last cycle of a loaded count, so a count of
// N held in SETTLE state produces a transition after N cycles.
module mux8_settle_timer
  import mux8_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on request, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/mux8_scanner.sv
// Sequencing front-end for the 8:1 structural multiplexer. Steps the select
// lines S2..S0 through channels 0..7, waits SETTLE cycles on each, samples Y
// into a shadow byte and hands the finished frame downstream over
// frame_valid/frame_ready.
// Optional feature: define MUX8_SCAN_AUTO_EN for continuous scanning, where
// each loaded frame is followed immediately by a new scan from channel 0.
module mux8_scanner
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic [7:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  // With no settle time a channel goes straight to its sample cycle
  localparam state_t CH_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

`ifdef MUX8_SCAN_AUTO_EN
  localparam state_t AFTER_LOAD = CH_ENTRY;
`else
  localparam state_t AFTER_LOAD = ST_IDLE;
`endif

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] frame_src;
  logic              handshake;
  logic              slot_free;
  logic              load_frame;
  logic              timer_load;
  logic              timer_done;

  mux8_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .done     (timer_done)
  );

  assign handshake = frame_valid & frame_ready;
  assign slot_free = ~frame_valid | frame_ready;

  // A frame completed in SAMPLE still needs this cycle's Y as its top bit
  assign frame_src = (state == ST_SAMPLE) ? {Y, shadow[NUM_CH-2:0]} : shadow;

  // Next-state, next-select and frame-load decisions
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    load_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = CH_ENTRY;
          sel_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (timer_done) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (sel != LAST_CH) begin
          sel_nxt   = sel + 1'b1;
          state_nxt = CH_ENTRY;
        end else if (slot_free) begin
          load_frame = 1'b1;
          sel_nxt    = '0;
          state_nxt  = AFTER_LOAD;
        end else begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (handshake) begin
          load_frame = 1'b1;
          sel_nxt    = '0;
          state_nxt  = AFTER_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  // The settle count restarts only on entry into SETTLE
  always_comb begin
    timer_load = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
  end

  // State and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Shadow byte collects one Y sample per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (state == ST_SAMPLE) begin
      shadow[sel] <= Y;
    end
  end

  // Output slot: a new frame overrides a same-edge handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (load_frame) begin
      frame_data  <= frame_src;
      frame_valid <= 1'b1;
    end else if (handshake) begin
      frame_valid <= 1'b0;
    end
  end

  assign S0   = sel[0];
  assign S1   = sel[1];
  assign S2   = sel[2];
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux8_scanner.sv
// Directed bench for mux8_scanner. Instance a uses SETTLE=1, instance b
// uses SETTLE=0; each has its own Y pattern indexed by its select lines.
module tb_mux8_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_a = 1'b0, ready_a = 1'b1;
  logic [7:0] pat_a = 8'h00;
  logic       y_a, s0_a, s1_a, s2_a, valid_a, busy_a;
  logic [7:0] data_a;
  logic [2:0] sel_a;

  logic       start_b = 1'b0, ready_b = 1'b1;
  logic [7:0] pat_b = 8'h00;
  logic       y_b, s0_b, s1_b, s2_b, valid_b, busy_b;
  logic [7:0] data_b;
  logic [2:0] sel_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sel_a = {s2_a, s1_a, s0_a};
  assign sel_b = {s2_b, s1_b, s0_b};
  assign y_a   = pat_a[sel_a];
  assign y_b   = pat_b[sel_b];

  mux8_scanner #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .Y(y_a),
    .S0(s0_a), .S1(s1_a), .S2(s2_a),
    .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .busy(busy_a)
  );

  mux8_scanner #(.SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .Y(y_b),
    .S0(s0_b), .S1(s1_b), .S2(s2_b),
    .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .busy(busy_b)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (sel_a !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_sel_a got %0d want 0", sel_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_a got %b want 0", valid_a); end
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data_a got %h want 00", data_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy_a got %b want 0", busy_a); end
    n_checks++; if ({sel_b, valid_b, busy_b, data_b} !== 13'd0) begin n_fail++; $display("[TB] FAIL reset_b got %h want 0", {sel_b, valid_b, busy_b, data_b}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pat_a = 8'hA5; ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy got %b want 1", busy_a); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (sel_a !== 3'(k)) begin n_fail++; $display("[TB] FAIL basic_sel got %0d want %0d", sel_a, k); end
      tick();
      n_checks++; if (sel_a !== 3'(k)) begin n_fail++; $display("[TB] FAIL basic_sel_hold got %0d want %0d", sel_a, k); end
      if (k == 7) begin
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid got %b want 0", valid_a); end
      end
      tick();
    end
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid got %b want 1", valid_a); end
    n_checks++; if (data_a !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_data got %h want a5", data_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle got %b want 0", busy_a); end
    n_checks++; if (sel_a !== 3'd0) begin n_fail++; $display("[TB] FAIL basic_sel_ret got %0d want 0", sel_a); end
    tick();
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_accept got %b want 0", valid_a); end
  endtask

  task automatic test_zero_settle();
    pat_b = 8'h3C; ready_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (sel_b !== 3'(k)) begin n_fail++; $display("[TB] FAIL zero_sel got %0d want %0d", sel_b, k); end
      tick();
    end
    n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_valid got %b want 1", valid_b); end
    n_checks++; if (data_b !== 8'h3C) begin n_fail++; $display("[TB] FAIL zero_data got %h want 3c", data_b); end
    tick();
  endtask

  task automatic test_backpressure();
    ready_a = 1'b0; pat_a = 8'hFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (16) tick();
    n_checks++; if ({valid_a, data_a} !== 9'h1FF) begin n_fail++; $display("[TB] FAIL bp_first got %h want 1ff", {valid_a, data_a}); end
    pat_a = 8'h01; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (16) tick();
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_full_busy got %b want 1", busy_a); end
    n_checks++; if (sel_a !== 3'd7) begin n_fail++; $display("[TB] FAIL bp_full_sel got %0d want 7", sel_a); end
    repeat (3) tick();
    n_checks++; if (data_a !== 8'hFF) begin n_fail++; $display("[TB] FAIL bp_hold_data got %h want ff", data_a); end
    n_checks++; if ({busy_a, sel_a, valid_a} !== 5'b1_111_1) begin n_fail++; $display("[TB] FAIL bp_hold_state got %b want 11111", {busy_a, sel_a, valid_a}); end
    ready_a = 1'b1;
    tick();
    n_checks++; if (data_a !== 8'h01) begin n_fail++; $display("[TB] FAIL bp_release_data got %h want 01", data_a); end
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_valid got %b want 1", valid_a); end
    n_checks++; if ({busy_a, sel_a} !== 4'd0) begin n_fail++; $display("[TB] FAIL bp_release_idle got %h want 0", {busy_a, sel_a}); end
    tick();
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain got %b want 0", valid_a); end
  endtask

  task automatic test_ignored_start();
    int extra;
    extra = 0;
    pat_a = 8'h5A; ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    n_checks++; if (sel_a !== 3'd3) begin n_fail++; $display("[TB] FAIL ign_sel3 got %0d want 3", sel_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    n_checks++; if (sel_a !== 3'd6) begin n_fail++; $display("[TB] FAIL ign_sel6 got %0d want 6", sel_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (2) tick();
    n_checks++; if ({busy_a, valid_a} !== 2'b10) begin n_fail++; $display("[TB] FAIL ign_pre_load got %b want 10", {busy_a, valid_a}); end
    tick();
    n_checks++; if ({busy_a, valid_a, data_a} !== 10'h15A) begin n_fail++; $display("[TB] FAIL ign_load got %h want 15a", {busy_a, valid_a, data_a}); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_a || busy_a) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("[TB] FAIL ign_extra_activity got %0d want 0", extra); end
  endtask

  task automatic test_reset_midscan();
    ready_a = 1'b0; pat_a = 8'hFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (16) tick();
    pat_a = 8'hC3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    n_checks++; if ({sel_a, valid_a} !== 4'b100_1) begin n_fail++; $display("[TB] FAIL mid_pre got %b want 1001", {sel_a, valid_a}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({sel_a, valid_a, busy_a, data_a} !== 13'd0) begin n_fail++; $display("[TB] FAIL mid_async got %h want 0", {sel_a, valid_a, busy_a, data_a}); end
    tick();
    rst_n = 1'b1;
    ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++; if ({busy_a, sel_a} !== 4'b1_000) begin n_fail++; $display("[TB] FAIL mid_restart got %b want 1000", {busy_a, sel_a}); end
    repeat (16) tick();
    n_checks++; if ({valid_a, data_a} !== 9'h1C3) begin n_fail++; $display("[TB] FAIL mid_frame got %h want 1c3", {valid_a, data_a}); end
    tick();
  endtask

  task automatic test_auto();
    int idle_seen;
    idle_seen = 0;
    pat_a = 8'hFF; ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 15; i++) begin
        tick();
        if (!busy_a) idle_seen++;
      end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL auto_pre_valid got %b want 0", valid_a); end
      tick();
      if (!busy_a) idle_seen++;
      n_checks++; if ({valid_a, data_a} !== 9'h1FF) begin n_fail++; $display("[TB] FAIL auto_frame got %h want 1ff", {valid_a, data_a}); end
    end
    n_checks++; if (idle_seen !== 0) begin n_fail++; $display("[TB] FAIL auto_busy_drop got %0d want 0", idle_seen); end
  endtask

  initial begin
    test_reset();
`ifdef MUX8_SCAN_AUTO_EN
    test_auto();
`else
    test_basic();
    test_zero_settle();
    test_backpressure();
    test_ignored_start();
    test_reset_midscan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
